// File: rtl/e_mdu_ctrl_pkg.sv
// Shared constants for the E-stage multiply/divide unit.
// Op encodings (4 bits) and the default busy latencies.
// Optional feature macro: MDU_MADD_EN enables the madd/maddu/msub/msubu family.
package e_mdu_ctrl_pkg;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MD_none  = 4'd0,
    MD_mult  = 4'd1,
    MD_multu = 4'd2,
    MD_div   = 4'd3,
    MD_divu  = 4'd4,
    MD_mfhi  = 4'd5,
    MD_mflo  = 4'd6,
    MD_mthi  = 4'd7,
    MD_mtlo  = 4'd8,
    MD_madd  = 4'd9,
    MD_maddu = 4'd10,
    MD_msub  = 4'd11,
    MD_msubu = 4'd12
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for a busy period.
  function automatic logic md_is_start_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_mult, MD_multu, MD_div, MD_divu: r = 1'b1;
`ifdef MDU_MADD_EN
      MD_madd, MD_maddu, MD_msub, MD_msubu: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops whose result is a divide (latency DIV_CYCLES).
  function automatic logic md_is_div_op(input logic [3:0] op);
    return (op == MD_div) || (op == MD_divu);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational MDU datapath: produces the next HI/LO pair for a start op.
// With MDU_MADD_EN defined the multiply-accumulate family is computed too;
// otherwise those encodings leave HI/LO as presented.
module e_mdu_calc
  import e_mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_nx_o,
  output logic [31:0] lo_nx_o,
  output logic        div0_o
);

  logic [63:0]        a_sx, b_sx, a_zx, b_zx;
  logic [63:0]        prod_s, prod_u;
  logic               b_zero, div_ovf;
  logic [31:0]        b_sdiv, b_udiv;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign a_zx   = {32'd0, a_i};
  assign b_zx   = {32'd0, b_i};
  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign b_zero  = (b_i == 32'd0);
  assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  // Divisors are steered away from zero and from the signed overflow case so
  // the dividers never see an undefined operation; those cases are overridden below.
  assign b_sdiv  = (b_zero || div_ovf) ? 32'd1 : b_i;
  assign b_udiv  = b_zero ? 32'd1 : b_i;
  assign quo_s   = $signed(a_i) / $signed(b_sdiv);
  assign rem_s   = $signed(a_i) % $signed(b_sdiv);
  assign quo_u   = a_i / b_udiv;
  assign rem_u   = a_i % b_udiv;

  // Select the result for the requested op; default keeps HI/LO as they are.
  always_comb begin
    hi_nx_o = hi_i;
    lo_nx_o = lo_i;
    div0_o  = 1'b0;
    case (op_i)
      MD_mult:  {hi_nx_o, lo_nx_o} = prod_s;
      MD_multu: {hi_nx_o, lo_nx_o} = prod_u;
      MD_div: begin
        if (b_zero) begin
          div0_o = 1'b1;
        end else if (div_ovf) begin
          lo_nx_o = 32'h8000_0000;
          hi_nx_o = 32'd0;
        end else begin
          lo_nx_o = quo_s;
          hi_nx_o = rem_s;
        end
      end
      MD_divu: begin
        if (b_zero) begin
          div0_o = 1'b1;
        end else begin
          lo_nx_o = quo_u;
          hi_nx_o = rem_u;
        end
      end
`ifdef MDU_MADD_EN
      MD_madd:  {hi_nx_o, lo_nx_o} = {hi_i, lo_i} + prod_s;
      MD_maddu: {hi_nx_o, lo_nx_o} = {hi_i, lo_i} + prod_u;
      MD_msub:  {hi_nx_o, lo_nx_o} = {hi_i, lo_i} - prod_s;
      MD_msubu: {hi_nx_o, lo_nx_o} = {hi_i, lo_i} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, models MDU latency with a
// busy down-counter, and requests a stall while the D-stage op needs the MDU.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate family).
//
// state   | meaning
// ST_IDLE | no operation in flight; starts and mthi/mtlo accepted
// ST_BUSY | result held in shadow regs, counter running toward commit
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [3:0]  MDOp,
  input  logic        Req_Valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_Is_MD,
  output logic        Busy,
  output logic        MD_Stall,
  output logic [31:0] MD_Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      hi_nx_q, lo_nx_q;
  logic             div0_q;
  logic [31:0]      calc_hi, calc_lo;
  logic             calc_div0;
  logic             busy;
  logic             start, mt_hi, mt_lo, cnt_last;

  e_mdu_calc u_calc (
    .op_i    (MDOp),
    .a_i     (A),
    .b_i     (B),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .hi_nx_o (calc_hi),
    .lo_nx_o (calc_lo),
    .div0_o  (calc_div0)
  );

  assign busy     = (state_q == ST_BUSY);
  assign cnt_last = (cnt_q == CNT_W'(1));
  assign start    = Req_Valid && !busy && md_is_start_op(MDOp);
  assign mt_hi    = Req_Valid && !busy && (MDOp == MD_mthi);
  assign mt_lo    = Req_Valid && !busy && (MDOp == MD_mtlo);

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: idle until a start, busy until the counter reaches its last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_BUSY;
      ST_BUSY: if (cnt_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: busy flag, hazard stall request and the mfhi/mflo read port.
  always_comb begin
    Busy     = busy;
    MD_Stall = D_Is_MD && (busy || start);
    MD_Out   = 32'd0;
    if (MDOp == MD_mfhi)      MD_Out = hi_q;
    else if (MDOp == MD_mflo) MD_Out = lo_q;
  end

  // Latency down-counter: loaded on start, cleared on the commit edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= md_is_div_op(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (busy) begin
      cnt_q <= cnt_last ? '0 : cnt_q - CNT_W'(1);
    end
  end

  // Shadow result captured at start, held until commit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_nx_q <= 32'd0;
      lo_nx_q <= 32'd0;
      div0_q  <= 1'b0;
    end else if (start) begin
      hi_nx_q <= calc_hi;
      lo_nx_q <= calc_lo;
      div0_q  <= calc_div0;
    end
  end

  // Architectural HI/LO: commit at end of busy (skipped on divide by zero) or mt write.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (busy && cnt_last) begin
      if (!div0_q) begin
        hi_q <= hi_nx_q;
        lo_q <= lo_nx_q;
      end
    end else begin
      if (mt_hi) hi_q <= A;
      if (mt_lo) lo_q <= A;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: table of op vectors plus hand-written
// sequences for stall timing, ignored ops while busy and reset mid-divide.
module tb_e_mdu_ctrl;
  import e_mdu_ctrl_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  MDOp;
  logic        Req_Valid;
  logic [31:0] A, B;
  logic        D_Is_MD;
  logic        Busy, MD_Stall;
  logic [31:0] MD_Out, HI, LO;

  int n_checks = 0;
  int n_fail   = 0;

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Rst(Rst), .MDOp(MDOp), .Req_Valid(Req_Valid),
    .A(A), .B(B), .D_Is_MD(D_Is_MD), .Busy(Busy), .MD_Stall(MD_Stall),
    .MD_Out(MD_Out), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] op, input logic [31:0] a, b, hi, lo,
                              input int cyc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.cyc = cyc;
    vecs.push_back(v);
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checkint(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp = op; Req_Valid = 1'b1; A = a; B = b;
  endtask

  task automatic idle_in();
    MDOp = MD_none; Req_Valid = 1'b0; A = 32'd0; B = 32'd0;
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  initial begin
    int n;
    int stall_cnt;

    // Op vectors, each checked against the state left by the previous one.
    add(MD_mult,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    add(MD_multu, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5);
    add(MD_div,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    add(MD_divu,  32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 10);
    add(MD_div,   32'hFFFF_FFF9, 32'd0,        32'h0000_0001, 32'h7FFF_FFFC, 10);
    add(MD_div,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    add(MD_mthi,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'h8000_0000, 0);
    add(MD_mtlo,  32'd5,         32'd0,        32'h1234_5678, 32'h0000_0005, 0);
    add(MD_mthi,  32'd0,         32'd0,        32'h0000_0000, 32'h0000_0005, 0);
`ifdef MDU_MADD_EN
    add(MD_madd,  32'd2,         32'd3,        32'h0000_0000, 32'h0000_000B, 5);
    add(MD_msub,  32'd2,         32'd3,        32'h0000_0000, 32'h0000_0005, 5);
`else
    add(MD_madd,  32'd2,         32'd3,        32'h0000_0000, 32'h0000_0005, 0);
    add(MD_msub,  32'd2,         32'd3,        32'h0000_0000, 32'h0000_0005, 0);
`endif
    add(MD_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    add(MD_mult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5);
    add(MD_div,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    add(MD_div,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10);

    idle_in();
    D_Is_MD = 1'b0;
    Rst = 1'b1;
    step(); step();
    Rst = 1'b0;
    D_Is_MD = 1'b1;
    #1;
    check32("reset_busy",   {31'd0, Busy},     32'd0);
    check32("reset_hi",     HI,                32'd0);
    check32("reset_lo",     LO,                32'd0);
    check32("reset_mdout",  MD_Out,            32'd0);
    check32("reset_stall",  {31'd0, MD_Stall}, 32'd0);

    // mult in E with mflo held in D: stall for start cycle + 5 busy cycles.
    drive(MD_mult, 32'd5, 32'd7);
    #1;
    stall_cnt = MD_Stall ? 1 : 0;
    step();
    idle_in();
    #1;
    n = 0;
    while (MD_Stall && n < 100) begin
      n++;
      step();
    end
    stall_cnt += n;
    checkint("stall_cycles", stall_cnt, 6);
    D_Is_MD = 1'b0;
    drive(MD_mflo, 32'd0, 32'd0);
    #1;
    check32("mflo_after_stall", MD_Out, 32'd35);
    drive(MD_mfhi, 32'd0, 32'd0);
    #1;
    check32("mfhi_after_stall", MD_Out, 32'd0);
    idle_in();
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      idle_in();
      #1;
      n = 0;
      while (Busy && n < 200) begin
        n++;
        step();
      end
      checkint($sformatf("vec%0d_busy_cycles", i), n, vecs[i].cyc);
      check32($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
      check32($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
      drive(MD_mflo, 32'd0, 32'd0);
      #1;
      check32($sformatf("vec%0d_mflo", i), MD_Out, vecs[i].lo);
      idle_in();
      step();
    end

    // mthi followed directly by mfhi.
    drive(MD_mthi, 32'h1234_5678, 32'd0);
    step();
    drive(MD_mfhi, 32'd0, 32'd0);
    #1;
    check32("mthi_hi",    HI,            32'h1234_5678);
    check32("mthi_busy",  {31'd0, Busy}, 32'd0);
    check32("mthi_mfhi",  MD_Out,        32'h1234_5678);
    idle_in();
    step();

    // MDU ops presented while busy must be ignored.
    drive(MD_mult, 32'd3, 32'd4);
    step();
    idle_in();
    #1;
    n = 0;
    while (Busy && n < 200) begin
      if (n == 1)      drive(MD_mthi, 32'hDEAD_BEEF, 32'd0);
      else if (n == 2) drive(MD_div, 32'd9, 32'd3);
      else             idle_in();
      n++;
      step();
    end
    idle_in();
    #1;
    checkint("ignore_busy_cycles", n, 5);
    check32("ignore_hi", HI, 32'd0);
    check32("ignore_lo", LO, 32'd12);

    // Reset on the 4th busy cycle of a divide discards the result.
    drive(MD_mthi, 32'hAAAA_5555, 32'd0);
    step();
    drive(MD_div, 32'd100, 32'd7);
    step();
    idle_in();
    step(); step(); step();
    check32("pre_rst_busy", {31'd0, Busy}, 32'd1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    #1;
    check32("rst_mid_hi",   HI,            32'd0);
    check32("rst_mid_lo",   LO,            32'd0);
    check32("rst_mid_busy", {31'd0, Busy}, 32'd0);
    repeat (15) step();
    check32("rst_late_hi",  HI,            32'd0);
    check32("rst_late_lo",  LO,            32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
